// File: rtl/unidade_de_busca_pkg.sv
// Shared fetch-stage types: sequencer states and pcSource encodings used by the control unit.
// No logic; types and constants only. No backpressure.
package iz_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [1:0] PCSRC_NEXT   = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_REG    = 2'b10;
    localparam logic [1:0] PCSRC_JUMP   = 2'b11;

endpackage

// File: rtl/unidade_de_busca_debouncer.sv
// Key debouncer: 2-flop synchronizer, stability counter, and rising-edge pulse on the debounced level.
// Latency: 2 sync cycles plus DEBOUNCE_CYCLES stable samples before the pulse.
// Backpressure: none; the pulse is lost if the consumer is not listening that cycle.
module debouncer #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic key_raw,
    output logic key_level,
    output logic key_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(DEBOUNCE_CYCLES);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc;

    always_comb begin
        cnt_d     = '0;
        level_d   = level_q;
        key_pulse = 1'b0;
        cnt_inc   = cnt_q + 1'b1;
        if (sync2_q != level_q) begin
            if (cnt_inc == LIMIT) begin
                level_d   = ~level_q;
                key_pulse = ~level_q;
            end else begin
                cnt_d = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= key_raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign key_level = level_q;

endmodule

// File: rtl/unidade_de_busca.sv
// PC / fetch sequencer: RUN, WAIT_INPUT (stall for debounced confirm key) and HALTED; optional PC trap via UNIDADE_DE_BUSCA_PC_TRAP_EN.
// Latency: pc updates on the edge ending a commit cycle; commit is combinational.
// Backpressure: isInsert stalls retirement until a fresh confirm press; HALTED holds until reset.
module unidade_de_busca
    import iz_pkg::*;
#(
    parameter int                 ADDR_WIDTH      = 10,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC     = '0,
    parameter int                 DEBOUNCE_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            pcSource,
    input  logic                  isHalt,
    input  logic                  isInsert,
    input  logic                  confirmKey,
    input  logic [25:0]           jumpAddr,
    input  logic [15:0]           branchAddr,
    input  logic [31:0]           regAddr,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [ADDR_WIDTH-1:0] pcPlus1,
    output logic                  commit,
    output logic                  halted,
    output logic                  waiting,
    output logic                  pcFault
);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [32:0]           next_full;
    logic                  advance;
    logic                  confirm_level;
    logic                  confirm_pulse;

    debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_confirm (
        .clk       (clk),
        .reset     (reset),
        .key_raw   (confirmKey),
        .key_level (confirm_level),
        .key_pulse (confirm_pulse)
    );

    // Untruncated target kept one bit wider than regAddr so the trap can see PC+1 overflow.
    always_comb begin
        next_full = 33'(pc_q) + 33'd1;
        case (pcSource)
            PCSRC_BRANCH: next_full = 33'(branchAddr);
            PCSRC_REG:    next_full = 33'(regAddr);
            PCSRC_JUMP:   next_full = 33'(jumpAddr);
            default:      next_full = 33'(pc_q) + 33'd1;
        endcase
    end

`ifdef UNIDADE_DE_BUSCA_PC_TRAP_EN
    logic fault_q, fault_d;
    logic overflow;
    assign overflow = (next_full >= (33'd1 << ADDR_WIDTH));
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        advance = 1'b0;
`ifdef UNIDADE_DE_BUSCA_PC_TRAP_EN
        fault_d = fault_q;
`endif
        case (state_q)
            ST_RUN: begin
                if (isHalt)        state_d = ST_HALT;
                else if (isInsert) state_d = ST_WAIT;
                else               advance = 1'b1;
            end
            ST_WAIT: advance = confirm_pulse;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RUN;
        endcase
        if (advance) begin
            state_d = ST_RUN;
`ifdef UNIDADE_DE_BUSCA_PC_TRAP_EN
            if (overflow) begin
                state_d = ST_HALT;
                fault_d = 1'b1;
            end else begin
                pc_d = next_full[ADDR_WIDTH-1:0];
            end
`else
            pc_d = next_full[ADDR_WIDTH-1:0];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
`ifdef UNIDADE_DE_BUSCA_PC_TRAP_EN
            fault_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
`ifdef UNIDADE_DE_BUSCA_PC_TRAP_EN
            fault_q <= fault_d;
`endif
        end
    end

    assign pc      = pc_q;
    assign pcPlus1 = pc_q + 1'b1;
    assign commit  = advance;
    assign halted  = (state_q == ST_HALT);
    assign waiting = (state_q == ST_WAIT);
`ifdef UNIDADE_DE_BUSCA_PC_TRAP_EN
    assign pcFault = fault_q;
`else
    assign pcFault = 1'b0;
`endif

endmodule

// File: tb/tb_unidade_de_busca.sv
// Directed bench for unidade_de_busca (ADDR_WIDTH=10, DEBOUNCE_CYCLES=16); honours UNIDADE_DE_BUSCA_PC_TRAP_EN.
module tb_unidade_de_busca;

    logic        clk;
    logic        reset;
    logic [1:0]  pcSource;
    logic        isHalt;
    logic        isInsert;
    logic        confirmKey;
    logic [25:0] jumpAddr;
    logic [15:0] branchAddr;
    logic [31:0] regAddr;
    logic [9:0]  pc;
    logic [9:0]  pcPlus1;
    logic        commit;
    logic        halted;
    logic        waiting;
    logic        pcFault;

    int total = 0;
    int bad   = 0;

    unidade_de_busca #(
        .ADDR_WIDTH      (10),
        .RESET_PC        (10'd0),
        .DEBOUNCE_CYCLES (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pcSource   (pcSource),
        .isHalt     (isHalt),
        .isInsert   (isInsert),
        .confirmKey (confirmKey),
        .jumpAddr   (jumpAddr),
        .branchAddr (branchAddr),
        .regAddr    (regAddr),
        .pc         (pc),
        .pcPlus1    (pcPlus1),
        .commit     (commit),
        .halted     (halted),
        .waiting    (waiting),
        .pcFault    (pcFault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold the key for 'hold' cycles; report commits seen, the cycle of the last one,
    // and the waiting flag on the cycle after it.
    task automatic press(input int hold, output int ncommit, output int at, output logic w_after);
        ncommit    = 0;
        at         = -1;
        w_after    = 1'b1;
        confirmKey = 1'b1;
        for (int i = 1; i <= hold; i++) begin
            tick();
            if (commit) begin
                ncommit++;
                at = i;
            end
            if (at >= 0 && i == at + 1) w_after = waiting;
        end
        confirmKey = 1'b0;
    endtask

    task automatic idle_count(input int n, output int ncommit);
        ncommit = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (commit) ncommit++;
        end
    endtask

    initial begin
        int          n;
        int          at;
        logic        w;
        logic [25:0] jval;

`ifdef UNIDADE_DE_BUSCA_PC_TRAP_EN
        jval = 26'h000_0123;
`else
        jval = 26'h3FF_0123;
`endif
        reset = 1'b1; pcSource = 2'b00; isHalt = 1'b0; isInsert = 1'b0;
        confirmKey = 1'b0; jumpAddr = '0; branchAddr = '0; regAddr = '0;
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_waiting", 32'(waiting), 32'd0);
        chk("rst_fault", 32'(pcFault), 32'd0);
        chk("rst_commit", 32'(commit), 32'd1);
        chk("rst_pcplus1", 32'(pcPlus1), 32'd1);

        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("seq_pc", 32'(pc), 32'(i));
            chk("seq_commit", 32'(commit), 32'd1);
        end

        pcSource = 2'b11; jumpAddr = jval;
        tick();
        chk("jump_pc", 32'(pc), 32'h123);
        pcSource = 2'b10; regAddr = 32'h5;
        tick();
        chk("jr_pc", 32'(pc), 32'h5);
        pcSource = 2'b01; branchAddr = 16'h40;
        tick();
        chk("branch_pc", 32'(pc), 32'h40);
        pcSource = 2'b10; regAddr = 32'h7;
        tick();
        chk("to7_pc", 32'(pc), 32'h7);

        pcSource = 2'b00; isInsert = 1'b1;
        #1;
        chk("ins_commit", 32'(commit), 32'd0);
        tick();
        chk("ins_waiting", 32'(waiting), 32'd1);
        idle_count(100, n);
        chk("wait_commits", 32'(n), 32'd0);
        chk("wait_pc", 32'(pc), 32'h7);

        confirmKey = 1'b1;
        idle_count(5, n);
        confirmKey = 1'b0;
        idle_count(30, at);
        chk("glitch_commits", 32'(n + at), 32'd0);

        press(40, n, at, w);
        chk("hold_commits", 32'(n), 32'd1);
        chk("hold_commit_cycle", 32'(at), 32'd17);
        chk("hold_waiting_after", 32'(w), 32'd0);
        chk("hold_pc", 32'(pc), 32'h8);
        idle_count(30, n);
        chk("release_commits", 32'(n), 32'd0);

        // Reset in the middle of a debounce count.
        confirmKey = 1'b1;
        idle_count(8, n);
        reset = 1'b1;
        tick();
        reset = 1'b0; confirmKey = 1'b0;
        #1;
        chk("midrst_pc", 32'(pc), 32'd0);
        chk("midrst_waiting", 32'(waiting), 32'd0);
        tick();
        chk("midrst_rewait", 32'(waiting), 32'd1);
        idle_count(30, n);
        chk("midrst_stale", 32'(n), 32'd0);
        pcSource = 2'b10; regAddr = 32'h9;
        press(18, n, at, w);
        chk("fresh_commits", 32'(n), 32'd1);
        chk("fresh_cycle", 32'(at), 32'd17);
        chk("fresh_pc", 32'(pc), 32'h9);

        isHalt = 1'b1; isInsert = 1'b1; pcSource = 2'b00;
        #1;
        chk("halt_commit", 32'(commit), 32'd0);
        tick();
        chk("halt_flag", 32'(halted), 32'd1);
        chk("halt_waiting", 32'(waiting), 32'd0);
        press(40, n, at, w);
        chk("halt_press_commits", 32'(n), 32'd0);
        idle_count(30, n);
        chk("halt_idle_commits", 32'(n), 32'd0);
        chk("halt_pc", 32'(pc), 32'h9);
        reset = 1'b1;
        tick();
        reset = 1'b0; isHalt = 1'b0; isInsert = 1'b0;
        #1;
        chk("unhalt_pc", 32'(pc), 32'd0);
        chk("unhalt_flag", 32'(halted), 32'd0);

        pcSource = 2'b10; regAddr = 32'd1023;
        tick();
        chk("max_pc", 32'(pc), 32'd1023);
        pcSource = 2'b00;
        #1;
        chk("max_pcplus1", 32'(pcPlus1), 32'd0);
        chk("max_commit", 32'(commit), 32'd1);
        tick();
`ifdef UNIDADE_DE_BUSCA_PC_TRAP_EN
        chk("trap_pc", 32'(pc), 32'd1023);
        chk("trap_halted", 32'(halted), 32'd1);
        chk("trap_fault", 32'(pcFault), 32'd1);
        tick();
        chk("trap_fault_sticky", 32'(pcFault), 32'd1);
`else
        chk("wrap_pc", 32'(pc), 32'd0);
        chk("wrap_halted", 32'(halted), 32'd0);
        chk("wrap_fault", 32'(pcFault), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
